golden_nonce_tx: RTL

GOLDEN_NONCE_TX -- requirements
Module: golden_nonce_tx

---
 rtl/ltcminer_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 101 ++++++++++
 rtl/golden_nonce_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ltcminer_pkg.sv
// Shared definitions for the ltcminer result path: UART frame constants,
// serializer state encoding and the default baud divisor.
package ltcminer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int BITS_PER_FRAME   = 10;
   localparam int BYTES_PER_NONCE  = 4;
   localparam int DEFAULT_BAUD_DIV = 868;

   // Counter reload value: a bit period runs from div-1 down to 0.
   function automatic logic [15:0] baud_reload(input int div);
      return 16'(div - 1);
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start seen while idle, or in the last stop-bit cycle,
// launches a frame; done is high during the final cycle of the stop bit.
module uart_tx_byte
   import ltcminer_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       txd,
   output logic       done
);

   localparam logic [15:0] RELOAD   = baud_reload(BAUD_DIV);
   localparam logic [2:0]  LAST_BIT = 3'(BITS_PER_FRAME - 3);

   tx_state_e   state_r;
   logic [15:0] baud_cnt_r;
   logic [2:0]  bit_idx_r;
   logic [7:0]  shift_r;
   logic        txd_r;
   logic        done_r;

   // Serializer FSM: start, eight data bits LSB first, stop; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         baud_cnt_r <= 16'd0;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'd0;
         txd_r      <= 1'b1;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r    <= START;
                  baud_cnt_r <= RELOAD;
                  shift_r    <= data;
                  bit_idx_r  <= 3'd0;
                  txd_r      <= 1'b0;
               end
            end
            START: begin
               if (baud_cnt_r == 16'd0) begin
                  state_r    <= DATA;
                  baud_cnt_r <= RELOAD;
                  txd_r      <= shift_r[0];
                  shift_r    <= {1'b0, shift_r[7:1]};
               end else begin
                  baud_cnt_r <= baud_cnt_r - 16'd1;
               end
            end
            DATA: begin
               if (baud_cnt_r == 16'd0) begin
                  baud_cnt_r <= RELOAD;
                  if (bit_idx_r == LAST_BIT) begin
                     state_r <= STOP;
                     txd_r   <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     txd_r     <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[7:1]};
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r - 16'd1;
               end
            end
            STOP: begin
               if (baud_cnt_r == 16'd0) begin
                  // Chaining straight into the next start bit keeps bytes gapless.
                  if (start) begin
                     state_r    <= START;
                     baud_cnt_r <= RELOAD;
                     shift_r    <= data;
                     bit_idx_r  <= 3'd0;
                     txd_r      <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     txd_r   <= 1'b1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r - 16'd1;
                  done_r     <= (baud_cnt_r == 16'd1);
               end
            end
            default: begin
               state_r <= IDLE;
               txd_r   <= 1'b1;
            end
         endcase
      end
   end

   assign txd  = txd_r;
   assign done = done_r;

endmodule

// File: rtl/golden_nonce_tx.sv
// Queues golden nonces from the hashcore and streams each one over the UART
// as four bytes, most-significant byte first.
module golden_nonce_tx
   import ltcminer_pkg::*;
#(
   parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        hash_clk,
   input  logic        reset_n,
   input  logic        golden_nonce_match,
   input  logic [31:0] golden_nonce,
   output logic        uart_txd,
   output logic        busy,
   output logic        overflow
);

   localparam int         ADDR_W    = $clog2(FIFO_DEPTH);
   localparam int         PTR_W     = ADDR_W + 1;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_NONCE - 1);

   logic [31:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [31:0]      shift_r;
   logic [1:0]       byte_idx_r;
   logic             active_r;
   logic             go_r;
   logic             busy_r;
   logic             overflow_r;

   logic [PTR_W-1:0] wr_ptr_n_s;
   logic [PTR_W-1:0] rd_ptr_n_s;
   logic             full_s;
   logic             empty_s;
   logic             last_byte_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic             start_s;
   logic             active_n_s;
   logic             byte_done_s;
   logic             byte_txd_s;

   // Queue status, pop/push arbitration and byte sequencing decisions.
   always_comb begin
      full_s      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                    (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
      empty_s     = (wr_ptr_r == rd_ptr_r);
      last_byte_s = (byte_idx_r == LAST_BYTE);
      // Pop when idle, or in the very cycle the last stop bit ends.
      pop_s       = !empty_s && (!active_r || (byte_done_s && last_byte_s));
      push_s      = golden_nonce_match && (!full_s || pop_s);
      drop_s      = golden_nonce_match && full_s && !pop_s;
      start_s     = go_r || (byte_done_s && !last_byte_s);
      wr_ptr_n_s  = wr_ptr_r + PTR_W'(push_s);
      rd_ptr_n_s  = rd_ptr_r + PTR_W'(pop_s);
      if (pop_s) begin
         active_n_s = 1'b1;
      end else if (byte_done_s && last_byte_s) begin
         active_n_s = 1'b0;
      end else begin
         active_n_s = active_r;
      end
   end

   // FIFO storage; a simultaneous pop reads the old entry before it is overwritten.
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= 32'd0;
         end
      end else if (push_s) begin
         fifo_mem_r[wr_ptr_r[ADDR_W-1:0]] <= golden_nonce;
      end
   end

   // Pointers, nonce shift register, byte index and status flags.
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         shift_r    <= 32'd0;
         byte_idx_r <= 2'd0;
         active_r   <= 1'b0;
         go_r       <= 1'b0;
         busy_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_n_s;
         rd_ptr_r   <= rd_ptr_n_s;
         active_r   <= active_n_s;
         go_r       <= pop_s;
         busy_r     <= active_n_s || (wr_ptr_n_s != rd_ptr_n_s);
         overflow_r <= overflow_r | drop_s;
         if (pop_s) begin
            shift_r    <= fifo_mem_r[rd_ptr_r[ADDR_W-1:0]];
            byte_idx_r <= 2'd0;
         end else if (start_s) begin
            shift_r <= {shift_r[23:0], 8'h00};
         end
         if (byte_done_s && !last_byte_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
         end
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx_byte (
      .clk   (hash_clk),
      .rst_n (reset_n),
      .start (start_s),
      .data  (shift_r[31:24]),
      .txd   (byte_txd_s),
      .done  (byte_done_s)
   );

   assign uart_txd = byte_txd_s;
   assign busy     = busy_r;
   assign overflow = overflow_r;

endmodule
